adc_stats: RTL and testbench
============================

ADC_STATS -- requirements
Module: adc_stats

Interface
- REQ-001: Parameter OVFL_W, default 16, width of the per-window ADC overflow-cycle counter.
- REQ-002: adc_clk  input  1  sample clock; all state changes on its rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: adc_data  input  14  signed ADC sample, already registered on adc_clk; one sample per cycle.
- REQ-005: adc_ovfl  input  1  ADC over-range flag, qualified every cycle.
- REQ-006: win_len  input  4  window length code; window = 2^(win_len+8) samples (256 .. 8388608).
- REQ-007: snap_ack  input  1  consumer accepts the current snapshot.
- REQ-008: snap_valid  output  1  snapshot registers hold an unconsumed window result.
- REQ-009: snap_peak  output  14  unsigned peak |adc_data| of the snapshotted window.
- REQ-010: snap_ovfl  output  OVFL_W  count of adc_ovfl-high cycles in the snapshotted window.
- REQ-011: snap_ovr  output  1  sticky; at least one window result was dropped since the last accepted snapshot.
- REQ-012: snap_dc  output  14  signed window mean (present only under ADC_STATS_DC_EN; else tied 0).

Function
- REQ-013: Sample counter (23 bits) increments every cycle; window-end cycle is when counter equals 2^(win_len_cur+8)-1; counter then wraps to 0.
- REQ-014: win_len is latched into win_len_cur only at reset and on window-end cycles; mid-window changes take effect next window.
- REQ-015: Magnitude = adc_data<0 ? -adc_data : adc_data; -8192 saturates to 8191.
- REQ-016: Peak accumulator keeps the running max magnitude, including the window-end sample; it reloads with 0 in the cycle after window end (the first sample of the next window is compared against 0).
- REQ-017: Overflow accumulator adds 1 per adc_ovfl-high cycle, saturates at 2^OVFL_W-1, and includes the window-end sample.
- REQ-018: Latency: snapshot outputs and snap_valid update on the clock edge that ends the window-end cycle (visible the following cycle).
- REQ-019: Handshake: snap_valid stays high until snap_ack is sampled high; snap_ack while snap_valid is low is ignored.
- REQ-020: Window end with snap_valid=0, or with snap_valid=1 and snap_ack=1 in the same cycle -> load new snapshot, snap_valid=1, no drop.
- REQ-021: Window end with snap_valid=1 and snap_ack=0 -> result discarded, snapshot registers unchanged, snap_ovr set.
- REQ-022: snap_ovr clears when an ack is accepted, except that if the same cycle is a dropping window end the set wins (unreachable by REQ-020; set-priority stated for completeness).
- REQ-023: Snapshot registers change only on load (REQ-020) or reset; they are stable while snap_valid=1.

Reset
- REQ-024: rst=1 -> sample counter, peak and overflow accumulators, snap_valid, snap_peak, snap_ovfl, snap_ovr, snap_dc, and DC accumulator all 0; win_len_cur loads win_len.
- REQ-025: rst asserted mid-window discards the partial window; the first window after rst deasserts starts at counter 0 with full length.
- REQ-026: rst overrides snap_ack and all window-end actions in the same cycle.

Configuration
- REQ-027: Macro ADC_STATS_DC_EN defined -> 37-bit signed accumulator sums adc_data over the window; snap_dc = sum arithmetic-shifted right by (win_len_cur+8), truncated to 14 bits, loaded with the other snapshot fields; accumulator reloads with 0 after window end.
- REQ-028: ADC_STATS_DC_EN undefined -> no DC accumulator logic is synthesized; snap_dc is constant 0; all other behaviour is identical.

Verification
- REQ-029: win_len=0, adc_data ramps 0..255, adc_ovfl=0 -> snap_valid rises the cycle after sample 255; snap_peak=255, snap_ovfl=0.
- REQ-030: win_len=0, one sample -8192, others 0, adc_ovfl held high for the whole window -> snap_peak=8191; snap_ovfl=256 (OVFL_W=16), and with OVFL_W=4 snap_ovfl=15.
- REQ-031: snap_ack held 0 across two window ends -> second result dropped, snap_ovr=1, snap_peak retains first-window value; ack -> snap_valid=0, snap_ovr=0.
- REQ-032: snap_ack=1 exactly on a window-end cycle with snap_valid=1 -> new snapshot loaded, snap_valid stays 1, snap_ovr stays 0.
- REQ-033: win_len switched 0->1 at sample 100, then rst pulsed mid-window -> current window still ends at 256 samples, next window 512; after rst: all outputs 0, next snapshot 512 samples after rst deasserts.
- REQ-034: ADC_STATS_DC_EN defined, win_len=0, adc_data constant -300 -> snap_dc=-300; undefined -> snap_dc=0.

Source files
------------

// File: rtl/adc_stats_if.sv
// Sample/snapshot bundle for adc_stats: ADC samples and window control in, window snapshot out.
interface adc_stats_if #(
    parameter int unsigned OVFL_W = 16
);
    localparam int unsigned DATA_W = 14;
    localparam int unsigned WL_W   = 4;

    logic [DATA_W-1:0] adc_data;
    logic              adc_ovfl;
    logic [WL_W-1:0]   win_len;
    logic              snap_ack;
    logic              snap_valid;
    logic [DATA_W-1:0] snap_peak;
    logic [OVFL_W-1:0] snap_ovfl;
    logic              snap_ovr;
    logic [DATA_W-1:0] snap_dc;

    modport master (
        output adc_data, adc_ovfl, win_len, snap_ack,
        input  snap_valid, snap_peak, snap_ovfl, snap_ovr, snap_dc
    );

    modport slave (
        input  adc_data, adc_ovfl, win_len, snap_ack,
        output snap_valid, snap_peak, snap_ovfl, snap_ovr, snap_dc
    );
endinterface

// File: rtl/adc_stats.sv
// Per-window ADC statistics (peak magnitude, over-range count, optional mean) with a one-deep snapshot.
// Optional mean path is built only when ADC_STATS_DC_EN is defined.
module adc_stats #(
    parameter int unsigned OVFL_W = 16
) (
    input  logic         adc_clk,
    input  logic         rst,
    adc_stats_if.slave   bus
);
    localparam int unsigned DATA_W = 14;
    localparam int unsigned CNT_W  = 23;
    localparam int unsigned WL_W   = 4;
    localparam int unsigned SH_W   = 5;
    localparam int unsigned DC_W   = 37;
    localparam logic [DATA_W-1:0] MAG_MAX  = DATA_W'((1 << (DATA_W - 1)) - 1);
    localparam logic [DATA_W-1:0] NEG_FULL = DATA_W'(1 << (DATA_W - 1));
    localparam logic [OVFL_W-1:0] OVFL_MAX = '1;

    logic [CNT_W-1:0]  r_cnt;
    logic [WL_W-1:0]   r_win_len;
    logic [DATA_W-1:0] r_peak;
    logic [OVFL_W-1:0] r_ovfl;
    logic              r_snap_valid;
    logic [DATA_W-1:0] r_snap_peak;
    logic [OVFL_W-1:0] r_snap_ovfl;
    logic              r_snap_ovr;

    logic [SH_W-1:0]   w_shamt;
    logic [CNT_W-1:0]  w_last;
    logic              w_win_end;
    logic [DATA_W-1:0] w_mag;
    logic [DATA_W-1:0] w_peak_nxt;
    logic [OVFL_W-1:0] w_ovfl_nxt;
    logic              w_ack;
    logic              w_load;
    logic              w_drop;

    // Last counter value of the current window; a 2^23 window wraps the shifted one to all-ones.
    assign w_shamt   = SH_W'(r_win_len) + SH_W'(8);
    assign w_last    = CNT_W'(((CNT_W + 1)'(1) << w_shamt) - (CNT_W + 1)'(1));
    assign w_win_end = (r_cnt == w_last);

    always_comb begin
        w_mag = bus.adc_data;
        if (bus.adc_data == NEG_FULL) begin
            w_mag = MAG_MAX;
        end else if (bus.adc_data[DATA_W-1]) begin
            w_mag = (~bus.adc_data) + DATA_W'(1);
        end
    end

    assign w_peak_nxt = (w_mag > r_peak) ? w_mag : r_peak;
    assign w_ovfl_nxt = (bus.adc_ovfl && (r_ovfl != OVFL_MAX)) ? r_ovfl + OVFL_W'(1) : r_ovfl;

    assign w_ack  = bus.snap_ack && r_snap_valid;
    assign w_load = w_win_end && (!r_snap_valid || bus.snap_ack);
    assign w_drop = w_win_end && r_snap_valid && !bus.snap_ack;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_win_len    <= bus.win_len;
            r_peak       <= '0;
            r_ovfl       <= '0;
            r_snap_valid <= 1'b0;
            r_snap_peak  <= '0;
            r_snap_ovfl  <= '0;
            r_snap_ovr   <= 1'b0;
        end else begin
            r_cnt  <= w_win_end ? '0 : r_cnt + CNT_W'(1);
            r_peak <= w_win_end ? '0 : w_peak_nxt;
            r_ovfl <= w_win_end ? '0 : w_ovfl_nxt;
            if (w_win_end) begin
                r_win_len <= bus.win_len;
            end
            if (w_load) begin
                r_snap_peak <= w_peak_nxt;
                r_snap_ovfl <= w_ovfl_nxt;
            end
            if (w_load) begin
                r_snap_valid <= 1'b1;
            end else if (w_ack) begin
                r_snap_valid <= 1'b0;
            end
            // A drop in the same cycle as an accepted ack keeps the sticky flag set.
            if (w_drop) begin
                r_snap_ovr <= 1'b1;
            end else if (w_ack) begin
                r_snap_ovr <= 1'b0;
            end
        end
    end

    assign bus.snap_valid = r_snap_valid;
    assign bus.snap_peak  = r_snap_peak;
    assign bus.snap_ovfl  = r_snap_ovfl;
    assign bus.snap_ovr   = r_snap_ovr;

`ifdef ADC_STATS_DC_EN
    logic signed [DC_W-1:0] r_dc_acc;
    logic signed [DC_W-1:0] w_dc_sum;
    logic [DATA_W-1:0]      r_snap_dc;

    assign w_dc_sum = r_dc_acc + DC_W'($signed(bus.adc_data));

    // Mean is the window sum shifted by log2 of the window length.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_dc_acc  <= '0;
            r_snap_dc <= '0;
        end else begin
            r_dc_acc <= w_win_end ? '0 : w_dc_sum;
            if (w_load) begin
                r_snap_dc <= DATA_W'(w_dc_sum >>> w_shamt);
            end
        end
    end

    assign bus.snap_dc = r_snap_dc;
`else
    assign bus.snap_dc = '0;
`endif

endmodule

// File: tb/tb_adc_stats.sv
// Self-checking bench for adc_stats: directed window table, handshake/reset sequences, random run vs. a window model.
module tb_adc_stats;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adc_stats_if #(.OVFL_W(16)) bus  ();
    adc_stats_if #(.OVFL_W(4))  bus4 ();

    assign bus4.adc_data = bus.adc_data;
    assign bus4.adc_ovfl = bus.adc_ovfl;
    assign bus4.win_len  = bus.win_len;
    assign bus4.snap_ack = bus.snap_ack;

    adc_stats #(.OVFL_W(16)) u_dut  (.adc_clk(clk), .rst(rst), .bus(bus));
    adc_stats #(.OVFL_W(4))  u_dut4 (.adc_clk(clk), .rst(rst), .bus(bus4));

    // Reference model: keeps the raw samples of the open window and evaluates them at window end.
    int     q_data[$];
    bit     q_ovfl[$];
    int     m_wl;
    bit     m_valid, m_ovr;
    int     m_peak, m_ovfl, m_ovfl4;
    longint m_dc;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int d, input bit o, input bit ack, input bit r, input int wl);
        int     mag, p, c;
        longint s;
        if (r) begin
            q_data.delete(); q_ovfl.delete();
            m_wl = wl; m_valid = 0; m_ovr = 0;
            m_peak = 0; m_ovfl = 0; m_ovfl4 = 0; m_dc = 0;
            return;
        end
        q_data.push_back(d);
        q_ovfl.push_back(o);
        if (q_data.size() == (1 << (m_wl + 8))) begin
            p = 0; c = 0; s = 0;
            foreach (q_data[k]) begin
                mag = (q_data[k] < 0) ? -q_data[k] : q_data[k];
                if (mag > 8191) mag = 8191;
                if (mag > p) p = mag;
                c += int'(q_ovfl[k]);
                s += longint'(q_data[k]);
            end
            if (!m_valid || ack) begin
                if (m_valid && ack) m_ovr = 0;
                m_valid = 1;
                m_peak  = p;
                m_ovfl  = (c > 65535) ? 65535 : c;
                m_ovfl4 = (c > 15) ? 15 : c;
`ifdef ADC_STATS_DC_EN
                m_dc    = s >>> (m_wl + 8);
`else
                m_dc    = 0;
`endif
            end else begin
                m_ovr = 1;
            end
            q_data.delete(); q_ovfl.delete();
            m_wl = wl;
        end else if (ack && m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic check_model();
        chk("model_valid", bus.snap_valid, m_valid);
        chk("model_peak",  bus.snap_peak,  m_peak);
        chk("model_ovfl",  bus.snap_ovfl,  m_ovfl);
        chk("model_ovr",   bus.snap_ovr,   m_ovr);
        chk("model_dc",    $signed(bus.snap_dc), m_dc);
        chk("model_ovfl4", bus4.snap_ovfl, m_ovfl4);
    endtask

    task automatic step(input int d, input bit o, input bit ack, input bit r, input int wl);
        bus.adc_data = 14'(d);
        bus.adc_ovfl = o;
        bus.snap_ack = ack;
        bus.win_len  = 4'(wl);
        rst          = r;
        @(posedge clk);
        model_edge(d, o, ack, r, wl);
        #1;
        check_model();
    endtask

    function automatic void gen(input int kind, input int i, output int d, output bit o);
        case (kind)
            0:       begin d = i;                        o = 1'b0;     end
            1:       begin d = (i == 37) ? -8192 : 0;    o = 1'b1;     end
            2:       begin d = -300;                     o = i[0];     end
            3:       begin d = (i == 255) ? 8191 : -5;   o = (i == 255); end
            default: begin d = (i == 0) ? -8191 : 1;     o = (i < 20); end
        endcase
    endfunction

    typedef struct {
        int kind;
        int exp_peak;
        int exp_ovfl;
        int exp_ovfl4;
        int exp_dc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int d, wl_r, dc_exp;
        bit o;

        tbl[0] = '{kind: 0, exp_peak: 255,  exp_ovfl: 0,   exp_ovfl4: 0,  exp_dc: 127};
        tbl[1] = '{kind: 1, exp_peak: 8191, exp_ovfl: 256, exp_ovfl4: 15, exp_dc: -32};
        tbl[2] = '{kind: 2, exp_peak: 300,  exp_ovfl: 128, exp_ovfl4: 15, exp_dc: -300};
        tbl[3] = '{kind: 3, exp_peak: 8191, exp_ovfl: 1,   exp_ovfl4: 1,  exp_dc: 27};
        tbl[4] = '{kind: 4, exp_peak: 8191, exp_ovfl: 20,  exp_ovfl4: 15, exp_dc: -31};

        // Single 256-sample windows with known statistics.
        foreach (tbl[k]) begin
            step(0, 0, 0, 1, 0);
            chk("rst_valid", bus.snap_valid, 0);
            chk("rst_peak",  bus.snap_peak,  0);
            chk("rst_ovfl",  bus.snap_ovfl,  0);
            chk("rst_ovr",   bus.snap_ovr,   0);
            chk("rst_dc",    $signed(bus.snap_dc), 0);
            for (int i = 0; i < 256; i++) begin
                gen(tbl[k].kind, i, d, o);
                step(d, o, 0, 0, 0);
                if (i == 254) chk("tbl_early_valid", bus.snap_valid, 0);
            end
            dc_exp = tbl[k].exp_dc;
`ifndef ADC_STATS_DC_EN
            dc_exp = 0;
`endif
            chk("tbl_valid", bus.snap_valid, 1);
            chk("tbl_peak",  bus.snap_peak,  tbl[k].exp_peak);
            chk("tbl_ovfl",  bus.snap_ovfl,  tbl[k].exp_ovfl);
            chk("tbl_ovfl4", bus4.snap_ovfl, tbl[k].exp_ovfl4);
            chk("tbl_dc",    $signed(bus.snap_dc), dc_exp);
            step(0, 0, 1, 0, 0);
            chk("tbl_ack_clear", bus.snap_valid, 0);
        end

        // Unacknowledged second window is dropped and flagged.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 512; i++) step((i < 256) ? 1000 : 2000, 0, 0, 0, 0);
        chk("drop_valid", bus.snap_valid, 1);
        chk("drop_ovr",   bus.snap_ovr,   1);
        chk("drop_peak",  bus.snap_peak,  1000);
        step(0, 0, 1, 0, 0);
        chk("drop_ack_valid", bus.snap_valid, 0);
        chk("drop_ack_ovr",   bus.snap_ovr,   0);

        // Ack coinciding with window end loads the new result without a drop.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 512; i++) step((i < 256) ? 500 : -700, 0, (i == 511), 0, 0);
        chk("coinc_valid", bus.snap_valid, 1);
        chk("coinc_peak",  bus.snap_peak,  700);
        chk("coinc_ovr",   bus.snap_ovr,   0);
        step(0, 0, 1, 0, 0);

        // Mid-window length change applies next window; reset discards a partial window.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            step(i % 50, 0, 0, 0, (i >= 100) ? 1 : 0);
            if (i == 254) chk("wl_early_valid", bus.snap_valid, 0);
        end
        chk("wl_end256", bus.snap_valid, 1);
        for (int i = 0; i < 300; i++) step(3, 1, (i == 0), 0, 1);
        chk("wl_no_end300", bus.snap_valid, 0);
        step(0, 0, 0, 1, 1);
        chk("rst2_valid", bus.snap_valid, 0);
        chk("rst2_peak",  bus.snap_peak,  0);
        chk("rst2_ovfl",  bus.snap_ovfl,  0);
        for (int i = 0; i < 512; i++) begin
            step(7, 0, 0, 0, 1);
            if (i == 510) chk("wl512_early_valid", bus.snap_valid, 0);
        end
        chk("wl512_valid", bus.snap_valid, 1);
        chk("wl512_peak",  bus.snap_peak,  7);
        step(0, 0, 1, 0, 1);

        // Randomised traffic against the window model.
        wl_r = 0;
        step(0, 0, 0, 1, wl_r);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) wl_r = $urandom_range(0, 1);
            d = ($urandom_range(0, 19) == 0) ? -8192 : int'($urandom_range(0, 16383)) - 8192;
            step(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 1499) == 0), wl_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
